// File: rtl/sync_fifo_1w_2r.sv
// Single-clock FIFO: one entry written per cycle, entries read out in pairs.
// Flush mode lets a lone trailing entry be popped on its own at end of stream.
module sync_fifo_1w_2r #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 3,
  parameter int FIFO_DEPTH    = (1 << ADDRESS_WIDTH)
) (
  input  logic                     Clk,
  input  logic                     Clear_in,
  input  logic [DATA_WIDTH-1:0]    Data_in,
  input  logic                     WriteEn_in,
  output logic                     Full_out,
  input  logic                     ReadEn_in,
  input  logic                     Flush_in,
  output logic [DATA_WIDTH-1:0]    Data_out_1,
  output logic [DATA_WIDTH-1:0]    Data_out_2,
  output logic                     Data_valid_1,
  output logic                     Data_valid_2,
  output logic                     Empty_out,
  output logic [ADDRESS_WIDTH:0]   Count_out,
  output logic                     Error_out
);

  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW:0] CNT_ZERO = '0;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         rd_ptr_p1;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic [DATA_WIDTH-1:0] dout2_q, dout2_d;
  logic                  dv1_q, dv1_d;
  logic                  dv2_q, dv2_d;
  logic                  err_q, err_d;

  logic full, wr_acc, rd2, rd1;

  // All accept decisions look only at the count registered at cycle start,
  // so a same-cycle read never makes room for a write and there is no bypass.
  assign full      = (count_q == CNT_FULL);
  assign wr_acc    = WriteEn_in & ~full;
  assign rd2       = ReadEn_in & (count_q >= CNT_TWO);
  assign rd1       = ReadEn_in & Flush_in & (count_q == CNT_ONE);
  assign rd_ptr_p1 = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout1_d  = dout1_q;
    dout2_d  = dout2_q;
    dv1_d    = 1'b0;
    dv2_d    = 1'b0;
    err_d    = err_q | (WriteEn_in & full) | (ReadEn_in & (count_q == CNT_ZERO));

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);

    if (rd2) begin
      dout1_d  = mem_q[rd_ptr_q];
      dout2_d  = mem_q[rd_ptr_p1];
      dv1_d    = 1'b1;
      dv2_d    = 1'b1;
      rd_ptr_d = rd_ptr_q + AW'(2);
    end else if (rd1) begin
      dout1_d  = mem_q[rd_ptr_q];
      dv1_d    = 1'b1;
      rd_ptr_d = rd_ptr_p1;
    end

    count_d = count_q + (AW+1)'(wr_acc) - (rd2 ? CNT_TWO : CNT_ZERO) - (AW+1)'(rd1);
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout1_q  <= '0;
      dout2_q  <= '0;
      dv1_q    <= 1'b0;
      dv2_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout1_q  <= dout1_d;
      dout2_q  <= dout2_d;
      dv1_q    <= dv1_d;
      dv2_q    <= dv2_d;
      err_q    <= err_d;
    end
  end

  // Storage is never reset; clearing the pointers is enough to discard it.
  always_ff @(posedge Clk) begin
    if (!Clear_in && wr_acc) mem_q[wr_ptr_q] <= Data_in;
  end

  assign Full_out     = full;
  assign Empty_out    = (count_q < CNT_TWO);
  assign Count_out    = count_q;
  assign Data_out_1   = dout1_q;
  assign Data_out_2   = dout2_q;
  assign Data_valid_1 = dv1_q;
  assign Data_valid_2 = dv2_q;
  assign Error_out    = err_q;

endmodule

// File: doc/sync_fifo_1w_2r.md
Name: sync_fifo_1w_2r

Overview:
Single-clock FIFO that accepts one entry per cycle and delivers entries in pairs (two per read). It is the read-side counterpart of the two-entry-write/one-read FIFO. It sits between a per-entry producer (e.g. one SMEM result per cycle) and a consumer that processes two entries per beat. A flush mode drains a lone leftover entry at end of stream.

Parameters:
DATA_WIDTH, 65, width of one entry
ADDRESS_WIDTH, 3, pointer width; minimum 2
FIFO_DEPTH, (1 << ADDRESS_WIDTH), number of entries; power of two, minimum 4

Ports:
Clk  input  1  single clock, all logic on rising edge
Clear_in  input  1  synchronous active-high reset/clear
Data_in  input  DATA_WIDTH  write entry
WriteEn_in  input  1  write request
Full_out  output  1  count == FIFO_DEPTH (combinational from registered count)
ReadEn_in  input  1  pair-read request
Flush_in  input  1  with ReadEn_in, allows popping a single remaining entry
Data_out_1  output  DATA_WIDTH  older entry of the read pair (registered)
Data_out_2  output  DATA_WIDTH  younger entry of the read pair (registered)
Data_valid_1  output  1  Data_out_1 valid, one-cycle pulse
Data_valid_2  output  1  Data_out_2 valid, one-cycle pulse
Empty_out  output  1  count < 2 (no full pair available)
Count_out  output  ADDRESS_WIDTH+1  current occupancy
Error_out  output  1  sticky misuse flag

Behaviour:
- State: Mem[FIFO_DEPTH]; binary wr_ptr and rd_ptr, ADDRESS_WIDTH bits, both wrapping modulo FIFO_DEPTH; count is ADDRESS_WIDTH+1 bits.
- Clear_in (dominates everything, any cycle, including mid-operation):
  - wr_ptr = rd_ptr = 0, count = 0.
  - Data_out_1/2 = 0, Data_valid_1/2 = 0, Error_out = 0.
  - Contents are discarded; Mem is not cleared.
- Reset-state outputs: Full_out = 0, Empty_out = 1, Count_out = 0.
- Write accept (wr_acc) = WriteEn_in & !Full_out.
  - Mem[wr_ptr] <= Data_in; wr_ptr += 1.
  - A write while full is dropped: no pointer change, no overwrite.
- Pair read (rd2) = ReadEn_in & (count >= 2).
  - Data_out_1 <= Mem[rd_ptr]; Data_out_2 <= Mem[rd_ptr+1 mod FIFO_DEPTH].
  - rd_ptr += 2 (wraps); Data_valid_1 = Data_valid_2 = 1 next cycle.
- Single flush read (rd1) = ReadEn_in & Flush_in & (count == 1).
  - Data_out_1 <= Mem[rd_ptr]; rd_ptr += 1.
  - Data_valid_1 = 1, Data_valid_2 = 0 next cycle.
  - Data_out_2 holds its previous value.
- ReadEn_in with count == 1 and Flush_in = 0: no pop, no valid, no error; the consumer waits.
- Flush_in with count >= 2: normal pair read (flush has no effect).
- Read latency is exactly 1 cycle from the accepted request to the valid pulse. With no accepted read, both valids are 0 and Data_out_1/2 hold their values.
- All accept decisions in a cycle use the count registered at the start of that cycle:
  - No bypass: an entry written in cycle N is readable no earlier than cycle N+1.
  - No write-through on full: a simultaneous read does not free space for the same-cycle write.
- Count update: count_next = count + wr_acc - 2*rd2 - rd1. Range stays 0..FIFO_DEPTH by construction.
- Wrap-around: a pair may straddle the end of the array (rd_ptr = FIFO_DEPTH-1 gives addresses FIFO_DEPTH-1, 0). Ordering is preserved.
- Error_out: set on WriteEn_in & Full_out, or on ReadEn_in & (count == 0). Sticky until Clear_in.
- Empty_out, Full_out and Count_out are combinational from the registered count, with no extra latency.

Test Plan:
- Clear, then write 0x1,0x2,0x3,0x4 on consecutive cycles, then ReadEn_in for 2 cycles -> pairs (0x1,0x2) then (0x3,0x4), each one cycle after its request, both valids high; Count_out 4->2->0; Empty_out = 1 at end; Error_out = 0.
- Write 3 entries 0xA,0xB,0xC; ReadEn_in twice with Flush_in = 0 -> first gives (0xA,0xB); second gives no valid, Count_out = 1. Then ReadEn_in + Flush_in -> Data_out_1 = 0xC, Data_valid_1 = 1, Data_valid_2 = 0, Count_out = 0.
- Depth 8: write 8 entries -> Full_out = 1. 9th write 0xFF is dropped and Error_out = 1. Subsequent reads return the original 8 in order, with no 0xFF.
- Wrap: pre-advance pointers with 7 writes, 6 reads and 1 flush read (rd_ptr = 7). Write 0x10, 0x11, then read -> pair (0x10,0x11) from addresses 7, 0.
- Simultaneous: count = 2 and full stream in progress, with WriteEn_in and ReadEn_in in the same cycle -> pair popped, new entry stored, Count_out = 1. With count = 8, simultaneous write + read -> write dropped, Count_out = 6, Error_out = 1.
- Clear_in asserted the cycle after a pair read is requested -> Data_valid_1/2 = 0, Count_out = 0, Empty_out = 1. Next write/read cycle returns only post-clear data.
